// File: rtl/lane_deserializer.sv
// lane_deserializer: one-lane serial-to-parallel receiver.
// Finds byte alignment from COM symbols, locks after COM_LOCK aligned COMs,
// then packs the following data bytes into 32-bit words (first byte in [31:24]).
// Optional feature macro: LANE_MISALIGN_DET_EN. It adds the misalign_err port
// and resyncs when a COM shows up off the byte boundary while ACTIVE.
module lane_deserializer #(
    parameter logic [7:0]  COM_BYTE = 8'hBC,
    parameter int unsigned COM_LOCK = 4
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic        data_in,
    output logic [31:0] lane_out,
    output logic        valid_out,
    output logic        active
`ifdef LANE_MISALIGN_DET_EN
    ,
    output logic        misalign_err
`endif
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_LOCKING = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    localparam logic [3:0] COM_LOCK_C = 4'(COM_LOCK);

    state_t      state_q, state_d;
    // Only seven history bits are needed: the eighth comes straight from data_in.
    logic [6:0]  sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  com_cnt_q, com_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] acc_q, acc_d;
    logic [31:0] lane_q, lane_d;
    logic        valid_q, valid_d;
    logic        active_q, active_d;
`ifdef LANE_MISALIGN_DET_EN
    logic        misalign_q, misalign_d;
`endif

    logic [7:0]  cur_byte;
    logic        is_com;
    logic        boundary;

    assign cur_byte = {sr_q, data_in};
    assign is_com   = (cur_byte == COM_BYTE);
    assign boundary = (bit_cnt_q == 3'd7);

    // Next-state logic: alignment search, lock counting and word assembly.
    always_comb begin
        state_d    = state_q;
        sr_d       = cur_byte[6:0];
        bit_cnt_d  = bit_cnt_q + 3'd1;
        com_cnt_d  = com_cnt_q;
        byte_cnt_d = byte_cnt_q;
        acc_d      = acc_q;
        lane_d     = lane_q;
        valid_d    = valid_q;
`ifdef LANE_MISALIGN_DET_EN
        misalign_d = 1'b0;
`endif
        case (state_q)
            ST_SEARCH: begin
                // Sliding-window hunt: any bit position may start a COM.
                if (is_com) begin
                    bit_cnt_d  = 3'd0;
                    com_cnt_d  = 4'd1;
                    byte_cnt_d = 2'd0;
                    if (COM_LOCK_C == 4'd1) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d = ST_LOCKING;
                    end
                end
            end
            ST_LOCKING: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if ((com_cnt_q + 4'd1) == COM_LOCK_C) begin
                            state_d    = ST_ACTIVE;
                            byte_cnt_d = 2'd0;
                        end
                    end else begin
                        com_cnt_d = 4'd0;
                        state_d   = ST_SEARCH;
                    end
                end
            end
            ST_ACTIVE: begin
                if (boundary) begin
                    if (is_com) begin
                        // COM inside a word drops the partial word; lane_out holds.
                        byte_cnt_d = 2'd0;
                        valid_d    = 1'b0;
                    end else begin
                        acc_d = {acc_q[15:0], cur_byte};
                        if (byte_cnt_q == 2'd3) begin
                            lane_d     = {acc_q, cur_byte};
                            valid_d    = 1'b1;
                            byte_cnt_d = 2'd0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end
                end
`ifdef LANE_MISALIGN_DET_EN
                else if (is_com) begin
                    // A COM off the boundary means we slipped: drop lock and re-hunt.
                    state_d    = ST_SEARCH;
                    valid_d    = 1'b0;
                    byte_cnt_d = 2'd0;
                    com_cnt_d  = 4'd0;
                    misalign_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d   = ST_SEARCH;
                com_cnt_d = 4'd0;
            end
        endcase
        active_d = (state_d == ST_ACTIVE);
    end

    // State and registered outputs; async reset clears everything, including any partial word.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= ST_SEARCH;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            com_cnt_q  <= '0;
            byte_cnt_q <= '0;
            acc_q      <= '0;
            lane_q     <= '0;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
`ifdef LANE_MISALIGN_DET_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            com_cnt_q  <= com_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            acc_q      <= acc_d;
            lane_q     <= lane_d;
            valid_q    <= valid_d;
            active_q   <= active_d;
`ifdef LANE_MISALIGN_DET_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign lane_out     = lane_q;
    assign valid_out    = valid_q;
    assign active       = active_q;
`ifdef LANE_MISALIGN_DET_EN
    assign misalign_err = misalign_q;
`endif

endmodule

// File: tb/tb_lane_deserializer.sv
// Directed bench for lane_deserializer: vector table plus hand-written corner sequences.
// The misalignment sequence is built only when LANE_MISALIGN_DET_EN is defined.
module tb_lane_deserializer;

    logic        clk;
    logic        reset_L;
    logic        data_in;
    logic [31:0] lane_out;
    logic        valid_out;
    logic        active;
`ifdef LANE_MISALIGN_DET_EN
    logic        misalign_err;
`endif

    int checks;
    int failures;

    lane_deserializer #(
        .COM_BYTE(8'hBC),
        .COM_LOCK(4)
    ) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .data_in  (data_in),
        .lane_out (lane_out),
        .valid_out(valid_out),
        .active   (active)
`ifdef LANE_MISALIGN_DET_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  din;
        logic        exp_active;
        logic        exp_valid;
        logic [31:0] exp_lane;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one bit; return #1 after the edge that samples it.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
        end
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        data_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_L = 1'b1;
    endtask

    task automatic lock4(input string tag);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hBC);
        end
        check({tag, "_locked"}, 32'(active), 32'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        data_in  = 1'b0;
        reset_L  = 1'b1;

        // Stream: lock, FF word, 88 word, 77 word, COM, 99 99 dropped by COM, 44 word.
        vecs[0]  = '{8'hBC, 1'b0, 1'b0, 32'h00000000};
        vecs[1]  = '{8'hBC, 1'b0, 1'b0, 32'h00000000};
        vecs[2]  = '{8'hBC, 1'b0, 1'b0, 32'h00000000};
        vecs[3]  = '{8'hBC, 1'b1, 1'b0, 32'h00000000};
        vecs[4]  = '{8'hFF, 1'b1, 1'b0, 32'h00000000};
        vecs[5]  = '{8'hFF, 1'b1, 1'b0, 32'h00000000};
        vecs[6]  = '{8'hFF, 1'b1, 1'b0, 32'h00000000};
        vecs[7]  = '{8'hFF, 1'b1, 1'b1, 32'hFFFFFFFF};
        vecs[8]  = '{8'h88, 1'b1, 1'b1, 32'hFFFFFFFF};
        vecs[9]  = '{8'h88, 1'b1, 1'b1, 32'hFFFFFFFF};
        vecs[10] = '{8'h88, 1'b1, 1'b1, 32'hFFFFFFFF};
        vecs[11] = '{8'h88, 1'b1, 1'b1, 32'h88888888};
        vecs[12] = '{8'h77, 1'b1, 1'b1, 32'h88888888};
        vecs[13] = '{8'h77, 1'b1, 1'b1, 32'h88888888};
        vecs[14] = '{8'h77, 1'b1, 1'b1, 32'h88888888};
        vecs[15] = '{8'h77, 1'b1, 1'b1, 32'h77777777};
        vecs[16] = '{8'hBC, 1'b1, 1'b0, 32'h77777777};
        vecs[17] = '{8'h99, 1'b1, 1'b0, 32'h77777777};
        vecs[18] = '{8'h99, 1'b1, 1'b0, 32'h77777777};
        vecs[19] = '{8'hBC, 1'b1, 1'b0, 32'h77777777};
        vecs[20] = '{8'h44, 1'b1, 1'b0, 32'h77777777};
        vecs[21] = '{8'h44, 1'b1, 1'b0, 32'h77777777};
        vecs[22] = '{8'h44, 1'b1, 1'b0, 32'h77777777};
        vecs[23] = '{8'h44, 1'b1, 1'b1, 32'h44444444};

        // T1: reset held with data toggling.
        #2 reset_L = 1'b0;
        for (int i = 0; i < 12; i++) begin
            send_bit(1'(i % 2));
            check("t1_lane", lane_out, 32'h0);
            check("t1_valid", 32'(valid_out), 32'd0);
            check("t1_active", 32'(active), 32'd0);
        end
        $display("T1 reset: checks=%0d failures=%0d", checks, failures);
        reset_L = 1'b1;

        // T2/T5 via vector table.
        for (int v = 0; v < 24; v++) begin
            send_byte(vecs[v].din);
            check($sformatf("vec%0d_active", v), 32'(active), 32'(vecs[v].exp_active));
            check($sformatf("vec%0d_valid", v), 32'(valid_out), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_lane", v), lane_out, vecs[v].exp_lane);
            $display("vec%0d din=%h active=%0d valid=%0d lane=%h", v, vecs[v].din,
                     active, valid_out, lane_out);
        end

        // T3: unaligned entry, back-to-back words 32 cycles apart.
        do_reset();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hBC);
            check("t3_not_yet_active", 32'(active), 32'd0);
        end
        send_byte(8'hBC);
        check("t3_active", 32'(active), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h88);
        end
        check("t3_word88", lane_out, 32'h88888888);
        check("t3_valid88", 32'(valid_out), 32'd1);
        begin
            logic [31:0] w77;
            w77 = 32'h77777777;
            for (int i = 31; i >= 1; i--) begin
                send_bit(w77[i]);
                check("t3_valid_between", 32'(valid_out), 32'd1);
                check("t3_lane_hold", lane_out, 32'h88888888);
            end
            send_bit(w77[0]);
        end
        check("t3_word77", lane_out, 32'h77777777);
        check("t3_valid77", 32'(valid_out), 32'd1);
        $display("T3 unaligned: lane=%h valid=%0d", lane_out, valid_out);

        // T4: lock abort then fresh lock.
        do_reset();
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h55);
        check("t4_abort_active", 32'(active), 32'd0);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hBC);
            check("t4_fresh_not_active", 32'(active), 32'd0);
        end
        send_byte(8'hBC);
        check("t4_relock_active", 32'(active), 32'd1);
        $display("T4 abort: active=%0d", active);

        // Reset mid-word: outputs clear at once, partial word discarded.
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hFF);
        end
        check("rst_pre_valid", 32'(valid_out), 32'd1);
        send_byte(8'hAA);
        send_byte(8'hAA);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset_L = 1'b0;
        #1;
        check("rst_async_valid", 32'(valid_out), 32'd0);
        check("rst_async_lane", lane_out, 32'h0);
        check("rst_async_active", 32'(active), 32'd0);
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        lock4("rst");
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        check("rst_no_early_valid", 32'(valid_out), 32'd0);
        send_byte(8'h78);
        check("rst_word", lane_out, 32'h12345678);
        check("rst_word_valid", 32'(valid_out), 32'd1);
        $display("reset mid-word: lane=%h valid=%0d", lane_out, valid_out);

`ifdef LANE_MISALIGN_DET_EN
        // T6: extra bit before a COM triggers resync.
        do_reset();
        lock4("t6");
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hFF);
        end
        check("t6_pre_valid", 32'(valid_out), 32'd1);
        send_bit(1'b0);
        begin
            logic [7:0] com;
            com = 8'hBC;
            for (int i = 7; i >= 1; i--) begin
                send_bit(com[i]);
            end
            check("t6_no_early_err", 32'(misalign_err), 32'd0);
            check("t6_valid_before", 32'(valid_out), 32'd1);
            send_bit(com[0]);
        end
        check("t6_err_pulse", 32'(misalign_err), 32'd1);
        check("t6_valid_drop", 32'(valid_out), 32'd0);
        check("t6_active_drop", 32'(active), 32'd0);
        send_bit(1'b1);
        check("t6_err_one_cycle", 32'(misalign_err), 32'd0);
        begin
            logic [7:0] com;
            com = 8'hBC;
            for (int i = 6; i >= 0; i--) begin
                send_bit(com[i]);
            end
        end
        check("t6_relock_1", 32'(active), 32'd0);
        send_byte(8'hBC);
        send_byte(8'hBC);
        check("t6_relock_3", 32'(active), 32'd0);
        send_byte(8'hBC);
        check("t6_relock_4", 32'(active), 32'd1);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        check("t6_word", lane_out, 32'hDEADBEEF);
        $display("T6 misalign: active=%0d lane=%h", active, lane_out);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
